// File: rtl/input_word_assembler.sv
// Frames shifter output into complete words: counts shift strobes, captures the
// shifter contents once a word has landed and queues it in a 2-entry FIFO.
module input_word_assembler #(
  parameter int unsigned SHIFT_DEPTH = 4,
  parameter int unsigned SHIFT_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               async_rst_n,
  input  logic                               clk_en_i,
  input  logic                               frame_i,
  input  logic                               shift_en_i,
  input  logic [SHIFT_DEPTH*SHIFT_WIDTH-1:0] data_i,
  output logic                               word_valid_o,
  input  logic                               word_ready_i,
  output logic [SHIFT_DEPTH*SHIFT_WIDTH-1:0] word_o,
  output logic                               overflow_o,
  output logic                               abort_o,
  input  logic                               clear_i
);

  localparam int unsigned W  = SHIFT_DEPTH * SHIFT_WIDTH;
  localparam int unsigned CW = (SHIFT_WIDTH > 2) ? $clog2(SHIFT_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SHIFT_WIDTH - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_cap, w_cap_nxt;
  logic          r_abort, w_abort_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic [W-1:0]  r_head, w_head_nxt;
  logic [W-1:0]  r_tail, w_tail_nxt;
  logic          r_head_vld, w_head_vld_nxt;
  logic          r_tail_vld, w_tail_vld_nxt;

  logic w_shift_evt, w_frame_end, w_pop, w_push, w_drop;

  assign w_shift_evt = clk_en_i & shift_en_i;
  assign w_frame_end = (r_state == ACTIVE) & clk_en_i & ~frame_i;
  assign w_pop       = r_head_vld & word_ready_i;
  assign w_push      = r_cap & (~r_tail_vld | w_pop);
  assign w_drop      = r_cap & r_tail_vld & ~w_pop;

  // Framing FSM and shift counter; frame end takes priority over a same-cycle shift.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_cap_nxt   = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (clk_en_i & frame_i) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (w_frame_end) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          w_abort_nxt = (r_count != '0);
        end else if (w_shift_evt) begin
          if (r_count == LAST_CNT) begin
            w_count_nxt = '0;
            w_cap_nxt   = 1'b1;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Two-entry FIFO kept as head/tail registers so the head drives word_o directly.
  always_comb begin
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_head_vld_nxt = r_head_vld;
    w_tail_vld_nxt = r_tail_vld;
    w_ovf_nxt      = r_ovf;
    if (clear_i) begin
      w_ovf_nxt      = 1'b0;
      w_tail_vld_nxt = 1'b0;
      w_head_vld_nxt = r_cap;
      if (r_cap) w_head_nxt = data_i;
    end else begin
      w_ovf_nxt = r_ovf | w_drop;
      if (w_pop) begin
        if (r_tail_vld) begin
          w_head_nxt     = r_tail;
          w_head_vld_nxt = 1'b1;
          w_tail_vld_nxt = w_push;
          if (w_push) w_tail_nxt = data_i;
        end else begin
          w_head_vld_nxt = w_push;
          if (w_push) w_head_nxt = data_i;
        end
      end else if (w_push) begin
        if (!r_head_vld) begin
          w_head_nxt     = data_i;
          w_head_vld_nxt = 1'b1;
        end else begin
          w_tail_nxt     = data_i;
          w_tail_vld_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_cap      <= 1'b0;
      r_abort    <= 1'b0;
      r_ovf      <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_cap      <= w_cap_nxt;
      r_abort    <= w_abort_nxt;
      r_ovf      <= w_ovf_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_head_vld <= w_head_vld_nxt;
      r_tail_vld <= w_tail_vld_nxt;
    end
  end

  assign word_o       = r_head;
  assign word_valid_o = r_head_vld;
  assign overflow_o   = r_ovf;
  assign abort_o      = r_abort;

endmodule

// File: tb/tb_input_word_assembler.sv
// Bench for input_word_assembler: a 4x4 shifter model feeds data_i, expected
// words go into a queue and a monitor compares every accepted FIFO head.
module tb_input_word_assembler;

  logic        clk = 1'b0;
  logic        async_rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        frame = 1'b0;
  logic        shift_en = 1'b0;
  logic [15:0] data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [15:0] word;
  logic        overflow;
  logic        abort_p;
  logic        clear = 1'b0;

  logic [3:0]  sh_in = 4'h0;
  logic [15:0] sh_reg = 16'h0;
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  input_word_assembler #(.SHIFT_DEPTH(4), .SHIFT_WIDTH(4)) dut (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .clk_en_i     (clk_en),
    .frame_i      (frame),
    .shift_en_i   (shift_en),
    .data_i       (data),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .word_o       (word),
    .overflow_o   (overflow),
    .abort_o      (abort_p),
    .clear_i      (clear)
  );

  // Shifter model: each of 4 lanes shifts in one bit of sh_in per enabled strobe.
  always @(posedge clk) begin
    if (clk_en && shift_en) begin
      for (int l = 0; l < 4; l++)
        sh_reg[l*4 +: 4] <= {sh_reg[l*4 +: 3], sh_in[l]};
    end
  end
  assign data = sh_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [3:0] nib);
    sh_in    = nib;
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic shift_word(input logic [15:0] nibs);
    for (int i = 3; i >= 0; i--) shift(nibs[i*4 +: 4]);
  endtask

  task automatic drain();
    word_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    word_ready = 1'b0;
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (async_rst_n && word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected none", word);
        end else begin
          e = exp_q.pop_front();
          chk("word_order", 32'(word), 32'(e));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    #12;
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_abort", 32'(abort_p), 32'd0);
    tick();
    async_rst_n = 1'b1;
    tick();

    // Single word, latency 2 cycles after the 4th shift
    frame = 1'b1;
    tick();
    exp_q.push_back(16'hAAAA);
    shift_word(16'hF0F0);
    chk("lat_capture_cycle_valid", 32'(word_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(word_valid), 32'd1);
    chk("lat_word", 32'(word), 32'hAAAA);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("pop_empty", 32'(word_valid), 32'd0);

    // Overflow: three words, consumer stalled
    exp_q.push_back(16'h1248);
    exp_q.push_back(16'h6666);
    shift_word(16'h1248);
    shift_word(16'h0FF0);
    shift_word(16'h33CC);
    tick();
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(word), 32'h1248);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);

    // Abort after 2 shifts
    shift(4'h5);
    shift(4'hA);
    frame = 1'b0;
    tick();
    chk("abort_pulse", 32'(abort_p), 32'd1);
    tick();
    chk("abort_one_cycle", 32'(abort_p), 32'd0);
    chk("abort_no_word", 32'(word_valid), 32'd0);
    frame = 1'b1;
    tick();
    shift(4'h1);
    shift(4'h2);
    shift(4'h4);
    tick();
    tick();
    chk("abort_fresh_count", 32'(word_valid), 32'd0);
    exp_q.push_back(16'h1248);
    shift(4'h8);
    tick();
    chk("abort_new_word", 32'(word), 32'h1248);
    drain();

    // Full FIFO with a capture coinciding with a pop
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h1248);
    exp_q.push_back(16'h6666);
    shift_word(16'hF0F0);
    shift_word(16'h1248);
    tick();
    tick();
    shift_word(16'h0FF0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("full_pop_push_ovf", 32'(overflow), 32'd0);
    chk("full_pop_push_head", 32'(word), 32'h1248);
    chk("full_pop_push_valid", 32'(word_valid), 32'd1);
    drain();
    chk("full_pop_push_ovf_end", 32'(overflow), 32'd0);

    // Shifts ignored with clk_en low and while IDLE
    clk_en = 1'b0;
    shift(4'h0);
    shift(4'h0);
    shift(4'h0);
    clk_en = 1'b1;
    shift(4'h3);
    tick();
    tick();
    chk("clken_low_ignored", 32'(word_valid), 32'd0);
    frame = 1'b0;
    tick();
    chk("clken_abort", 32'(abort_p), 32'd1);
    shift(4'h0);
    shift(4'h0);
    shift(4'h0);
    frame = 1'b1;
    tick();
    shift(4'h3);
    tick();
    tick();
    chk("idle_shift_ignored", 32'(word_valid), 32'd0);
    exp_q.push_back(16'h33CC);
    shift(4'h3);
    shift(4'hC);
    shift(4'hC);
    tick();
    chk("idle_then_word", 32'(word), 32'h33CC);
    drain();

    // Reset during a capture with one word queued
    shift_word(16'hF0F0);
    tick();
    tick();
    chk("prerst_valid", 32'(word_valid), 32'd1);
    shift_word(16'h1248);
    async_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(word_valid), 32'd0);
    chk("midrst_word", 32'(word), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_abort", 32'(abort_p), 32'd0);
    tick();
    async_rst_n = 1'b1;
    tick();
    chk("postrst_valid", 32'(word_valid), 32'd0);
    tick();
    shift(4'h0);
    shift(4'hF);
    shift(4'hF);
    tick();
    tick();
    chk("postrst_fresh_count", 32'(word_valid), 32'd0);
    exp_q.push_back(16'h6666);
    shift(4'h0);
    chk("postrst_capture_cycle", 32'(word_valid), 32'd0);
    tick();
    chk("postrst_word", 32'(word), 32'h6666);
    drain();

    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_word_assembler.md
# input_word_assembler

Consumes the parallel output of the input bit shifter and frames it into complete words. It counts shift strobes, captures the shifter contents once SHIFT_WIDTH shifts have landed, and presents each word on a valid/ready interface through a 2-entry output FIFO. It sits directly downstream of the shifter and is driven by the same shift strobe, clock enable and frame signal.

## Interface
- SHIFT_DEPTH, default 4: lanes in the shifter; must match the shifter instance.
- SHIFT_WIDTH, default 4: shifts per word, minimum 2; word width W = SHIFT_DEPTH*SHIFT_WIDTH.
- clk  in  1  system clock; all state updates on its rising edge.
- async_rst_n  in  1  reset; asynchronous, active-low.
- clk_en_i  in  1  clock enable; qualifies shift_en_i and frame_i only.
- frame_i  in  1  frame active; low means idle or abort the partial word.
- shift_en_i  in  1  the same strobe that drives the shifter's shift_en_i.
- data_i  in  W  shifter data_o, flattened; lane 0 occupies the LSBs.
- word_valid_o  out  1  FIFO head is valid.
- word_ready_i  in  1  consumer accepts the head.
- word_o  out  W  FIFO head word.
- overflow_o  out  1  sticky; a completed word was dropped because the FIFO was full.
- abort_o  out  1  one-cycle pulse; a frame ended with a partial word pending.
- clear_i  in  1  synchronous; clears overflow_o and flushes the FIFO.

## Operation
- FSM states:
  - IDLE → ACTIVE when clk_en_i & frame_i.
  - ACTIVE → IDLE when clk_en_i & !frame_i.
- Bit counter, width max(1, $clog2(SHIFT_WIDTH)):
  - Increments on each shift event (clk_en_i & shift_en_i) in ACTIVE.
  - A shift event when count == SHIFT_WIDTH-1 wraps count to 0 and sets capture_pending.
  - Shift events in IDLE are ignored; count stays 0.
- capture_pending:
  - Lasts exactly one cycle, because the shifter registers its final shift on the same edge.
  - During that cycle data_i holds the complete word and is pushed into the FIFO.
  - It is not gated by clk_en_i or frame_i once set.
- Pipelining: a shift event in the capture_pending cycle counts as bit 0 of the next word, so back-to-back words need no stall.
- Frame end:
  - ACTIVE → IDLE with count != 0 pulses abort_o and resets count to 0.
  - The partial word is discarded.
  - A pending capture still completes.
- FIFO:
  - 2 entries, first-in first-out.
  - Pop when word_valid_o & word_ready_i.
  - Push when capture_pending, if occupancy < 2, or occupancy == 2 with a pop in the same cycle.
  - Otherwise the word is dropped and overflow_o is set.
  - Simultaneous push and pop keeps occupancy unchanged.
- clear_i:
  - Empties the FIFO and clears overflow_o; an overflow event in the same cycle loses to clear.
  - A capture in the same cycle is still pushed, leaving 1 entry.
  - The FSM and counter are untouched.
- Arithmetic: unsigned, no saturation; the counter never exceeds SHIFT_WIDTH-1.

## Timing
- Reset values: state IDLE, count 0, capture_pending 0, FIFO empty.
- Output reset values: word_valid_o 0, word_o 0, overflow_o 0, abort_o 0.
- Latency: final shift event in cycle N → capture_pending in N+1 → word_valid_o and word_o valid in N+2 when the FIFO was empty.
- word_o and word_valid_o are registered outputs from FIFO storage, with no combinational path from word_ready_i.
- word_o is stable while word_valid_o & !word_ready_i.
- abort_o asserts in the cycle after the terminating frame_i sample.
- Reset asserted mid-word or mid-capture:
  - All state returns to reset values immediately (asynchronous).
  - No word is emitted.
  - The first word after reset needs a full SHIFT_WIDTH shift events.

## Test plan
- Defaults, frame_i high, 4 consecutive shift events with the shifter modelled: word_valid_o rises 2 cycles after the 4th shift; word_o equals the 16-bit shifter contents; ready high pops it the next cycle.
- 12 continuous shift events with word_ready_i held low: words 1 and 2 are held in the FIFO; word 3 is dropped and overflow_o = 1. Raising ready then yields words 1 and 2 in order. clear_i then drops overflow_o to 0.
- frame_i low after 2 shifts: abort_o pulses for exactly 1 cycle; no word is emitted. A new frame needs 4 fresh shifts to produce a word.
- FIFO full, capture_pending coincident with a pop: the push is accepted, occupancy stays 2, overflow_o stays 0.
- Shift events with clk_en_i low, or while in IDLE: count stays 0 and no word is produced.
- async_rst_n low for 1 cycle during capture_pending with the FIFO holding 1 word: all outputs are 0 immediately; word_valid_o stays 0 until a fresh 4-shift word completes.
